// File: rtl/ex_seq_pkg.sv
// Shared opcode, result-class and flag definitions for the execute stage.
// Also holds the multiply/divide sequencer state type and op decode helpers.
package ex_seq_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int REG_ADDR_W = 5;
  localparam int FLAG_W     = 5;

  typedef logic [ALU_OP_W-1:0]   aluop_t;
  typedef logic [ALU_SEL_W-1:0]  alusel_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam aluop_t EXE_NOP_OP   = 8'h00;
  localparam aluop_t EXE_SHR_OP   = 8'h02;
  localparam aluop_t EXE_SAR_OP   = 8'h03;
  localparam aluop_t EXE_SHL_OP   = 8'h04;
  localparam aluop_t EXE_MOVZ_OP  = 8'h0A;
  localparam aluop_t EXE_MOVN_OP  = 8'h0B;
  localparam aluop_t EXE_MOV_OP   = 8'h0C;
  localparam aluop_t EXE_MULT_OP  = 8'h18;
  localparam aluop_t EXE_MULTU_OP = 8'h19;
  localparam aluop_t EXE_DIV_OP   = 8'h1A;
  localparam aluop_t EXE_DIVU_OP  = 8'h1B;
  localparam aluop_t EXE_ADD_OP   = 8'h20;
  localparam aluop_t EXE_SUB_OP   = 8'h22;
  localparam aluop_t EXE_AND_OP   = 8'h24;
  localparam aluop_t EXE_OR_OP    = 8'h25;
  localparam aluop_t EXE_XOR_OP   = 8'h26;
  localparam aluop_t EXE_NOT_OP   = 8'h27;

  localparam alusel_t EXE_RES_NOP   = 3'd0;
  localparam alusel_t EXE_RES_LOGIC = 3'd1;
  localparam alusel_t EXE_RES_SHIFT = 3'd2;
  localparam alusel_t EXE_RES_MOVE  = 3'd3;
  localparam alusel_t EXE_RES_ARITH = 3'd4;

  localparam int FLAG_OV = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_SF = 3;
  localparam int FLAG_DZ = 4;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } md_op_t;

  function automatic logic is_md_op(aluop_t op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

  function automatic md_op_t decode_md(aluop_t op);
    md_op_t d;
    d.is_div    = (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    d.is_signed = (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
    return d;
  endfunction

endpackage

// File: rtl/ex_seq_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage.
// master drives the operation, slave (the execute stage) returns results.
interface ex_seq_if #(parameter int WIDTH = 32);
  import ex_seq_pkg::*;

  aluop_t             aluop_i;
  alusel_t            alusel_i;
  logic [WIDTH-1:0]   reg1_i;
  logic [WIDTH-1:0]   reg2_i;
  reg_addr_t          wd_i;
  logic               wreg_i;
  logic               flush_i;

  reg_addr_t          wd_o;
  logic               wreg_o;
  logic [WIDTH-1:0]   wdata_o;
  logic [WIDTH-1:0]   hi_o;
  logic [WIDTH-1:0]   lo_o;
  logic               whilo_o;
  logic [FLAG_W-1:0]  flags_o;
  logic               stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, flags_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, flags_o, stallreq_o
  );

endinterface

// File: rtl/ex_seq_muldiv.sv
// Iterative radix-2 multiply / restoring divide sequencer (IDLE -> BUSY -> DONE).
// Works on operand magnitudes; signs are re-applied when the last step lands.
module ex_seq_muldiv
  import ex_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  md_op_t           i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_dz,
  output logic             o_is_div
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_p;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_a_abs = (i_op.is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_abs = (i_op.is_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // Multiply: {hi,lo} holds partial product in hi and remaining multiplier bits in lo.
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

  // Divide: shift the next dividend bit into the remainder, keep the difference if no borrow.
  assign w_rem_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_a};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_p[WIDTH-2:0], 1'b1};

  assign w_step     = r_is_div ? w_div_next : w_mul_next;
  assign w_prod_fix = r_neg_q ? -w_step : w_step;
  assign w_q_fix    = r_neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
  assign w_r_fix    = r_neg_r ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start && !i_flush) begin
            r_cnt    <= '0;
            r_is_div <= i_op.is_div;
            r_neg_q  <= i_op.is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r  <= i_op.is_signed && i_op.is_div && i_a[WIDTH-1];
            if (i_op.is_div && (i_b == '0)) begin
              r_hi    <= i_a;
              r_lo    <= '1;
              r_dz    <= 1'b1;
              r_state <= MD_DONE;
            end else begin
              r_dz    <= 1'b0;
              r_state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (i_flush) begin
            r_state <= MD_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_hi    <= r_is_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo    <= r_is_div ? w_q_fix : w_prod_fix[WIDTH-1:0];
              r_state <= MD_DONE;
            end
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  // NOTE: operand/accumulator registers carry no reset; they are always loaded at issue before use.
  always_ff @(posedge clk) begin
    if (r_state == MD_IDLE && i_start && !i_flush) begin
      r_a <= w_b_abs;
      r_p <= {{WIDTH{1'b0}}, w_a_abs};
    end else if (r_state == MD_BUSY) begin
      r_p <= w_step;
    end
  end

  assign o_hi     = r_hi;
  assign o_lo     = r_lo;
  assign o_done   = (r_state == MD_DONE);
  assign o_busy   = (r_state == MD_BUSY);
  assign o_dz     = r_dz;
  assign o_is_div = r_is_div;

endmodule

// File: rtl/ex_seq.sv
// Execute stage: zero-latency ALU and result mux, registered flags,
// and the stall/HI-LO handshake around the iterative multiply/divide unit.
module ex_seq
  import ex_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  ex_seq_if.slave  bus
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]   w_shamt;
  logic              w_sub;
  logic [WIDTH-1:0]  w_b_op;
  logic [WIDTH:0]    w_sum;
  logic              w_ov;
  logic              w_is_addsub;
  logic [WIDTH-1:0]  w_result;
  md_op_t            w_md_op;
  logic              w_start;
  logic [WIDTH-1:0]  w_md_hi;
  logic [WIDTH-1:0]  w_md_lo;
  logic              w_md_done;
  logic              w_md_busy;
  logic              w_md_dz;
  logic              w_md_is_div;
  logic [FLAG_W-1:0] r_flags;

  assign w_shamt     = bus.reg2_i[SH_W-1:0];
  assign w_sub       = (bus.aluop_i == EXE_SUB_OP);
  assign w_is_addsub = (bus.aluop_i == EXE_ADD_OP) || w_sub;
  assign w_b_op      = w_sub ? ~bus.reg2_i : bus.reg2_i;
  assign w_sum       = {1'b0, bus.reg1_i} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};
  assign w_ov        = (bus.reg1_i[WIDTH-1] == w_b_op[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != bus.reg1_i[WIDTH-1]);

  // NOTE: default assignment first so no path leaves w_result unassigned (no latch).
  always_comb begin
    w_result = '0;
    case (bus.alusel_i)
      EXE_RES_LOGIC: begin
        case (bus.aluop_i)
          EXE_OR_OP:  w_result = bus.reg1_i | bus.reg2_i;
          EXE_AND_OP: w_result = bus.reg1_i & bus.reg2_i;
          EXE_XOR_OP: w_result = bus.reg1_i ^ bus.reg2_i;
          EXE_NOT_OP: w_result = ~bus.reg1_i;
          default:    w_result = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (bus.aluop_i)
          EXE_SHL_OP: w_result = bus.reg1_i << w_shamt;
          EXE_SHR_OP: w_result = bus.reg1_i >> w_shamt;
          EXE_SAR_OP: w_result = $signed(bus.reg1_i) >>> w_shamt;
          default:    w_result = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (bus.aluop_i)
          EXE_MOV_OP:                w_result = bus.reg1_i;
          EXE_MOVZ_OP, EXE_MOVN_OP:  w_result = bus.reg2_i;
          default:                   w_result = '0;
        endcase
      end
      EXE_RES_ARITH: w_result = w_is_addsub ? w_sum[WIDTH-1:0] : '0;
      default:       w_result = '0;
    endcase
  end

  // With DIV_EN clear, DIV/DIVU never start the sequencer and behave as NOP.
  assign w_md_op = decode_md(bus.aluop_i);
  assign w_start = is_md_op(bus.aluop_i) && (DIV_EN || !w_md_op.is_div);

  ex_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_op     (w_md_op),
    .i_a      (bus.reg1_i),
    .i_b      (bus.reg2_i),
    .i_flush  (bus.flush_i),
    .o_hi     (w_md_hi),
    .o_lo     (w_md_lo),
    .o_done   (w_md_done),
    .o_busy   (w_md_busy),
    .o_dz     (w_md_dz),
    .o_is_div (w_md_is_div)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flags <= '0;
    end else begin
      if (w_is_addsub) begin
        r_flags[FLAG_OV] <= w_ov;
        r_flags[FLAG_CF] <= w_sum[WIDTH];
        r_flags[FLAG_ZF] <= (w_sum[WIDTH-1:0] == '0);
        r_flags[FLAG_SF] <= w_sum[WIDTH-1];
      end
      if (w_md_done && w_md_is_div && !bus.flush_i)
        r_flags[FLAG_DZ] <= w_md_dz;
    end
  end

  // Issue-cycle stall is combinational so the upstream holds the op on the first cycle.
  assign bus.stallreq_o = rst && ((w_start && !bus.flush_i && !w_md_busy && !w_md_done) ||
                                  w_md_busy);
  assign bus.whilo_o    = w_md_done && !bus.flush_i;
  assign bus.hi_o       = w_md_hi;
  assign bus.lo_o       = w_md_lo;
  assign bus.flags_o    = r_flags;
  assign bus.wdata_o    = w_result;
  assign bus.wd_o       = bus.wd_i;
  assign bus.wreg_o     = bus.wreg_i && !is_md_op(bus.aluop_i);

endmodule
